// File: rtl/tetris_map_pkg.sv
// Shared playfield geometry, cell addressing and sequencer states for the
// fixed-square map logic.
package tetris_map_pkg;

    localparam int ROWS       = 14;
    localparam int COLS       = 10;
    localparam int COL_OFS    = 5;
    localparam int ROW_STRIDE = 20;
    localparam int MAP_W      = 360;
    localparam int IDX_W      = $clog2(MAP_W);
    localparam int PTR_W      = 4;
    localparam int LC_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        COMMIT
    } clear_state_t;

    // Bit position of playfield cell (r,c) inside the map vector
    function automatic logic [IDX_W-1:0] idx(input int r, input int c);
        return IDX_W'(COL_OFS + ROW_STRIDE * r + c);
    endfunction

endpackage

// File: rtl/line_clear_ctrl_module_if.sv
// Request/result bundle between the piece-lock logic, the line-clear
// sequencer and the fixed-map register owner.
interface line_clear_ctrl_module_if;

    logic                                 start;
    logic                                 vblank;
    logic [tetris_map_pkg::MAP_W-1:0]     fixed_square_map;
    logic                                 busy;
    logic [tetris_map_pkg::MAP_W-1:0]     map_out;
    logic                                 map_we;
    logic                                 done;
    logic [tetris_map_pkg::LC_W-1:0]      lines_cleared;

    modport master (
        output start, vblank, fixed_square_map,
        input  busy, map_out, map_we, done, lines_cleared
    );

    modport slave (
        input  start, vblank, fixed_square_map,
        output busy, map_out, map_we, done, lines_cleared
    );

endinterface

// File: rtl/row_full_detect.sv
// Combinational check that every playfield cell of the row selected by
// row_ptr is occupied.
module row_full_detect
    import tetris_map_pkg::*;
(
    input  logic [MAP_W-1:0] map,
    input  logic [PTR_W-1:0] row_ptr,
    output logic             row_full
);

    logic [COLS-1:0] row_bits;

    always_comb begin
        row_bits = COLS'(map >> idx(int'(row_ptr), 0));
        row_full = &row_bits;
    end

endmodule

// File: rtl/line_clear_ctrl_module.sv
// Line-clear sequencer: snapshots the fixed map, collapses full rows
// bottom-up one step per cycle and commits the result during vblank.
module line_clear_ctrl_module
    import tetris_map_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    line_clear_ctrl_module_if.slave bus
);

    clear_state_t     state;
    clear_state_t     state_next;
    logic [MAP_W-1:0] work;
    logic [MAP_W-1:0] shifted;
    logic [MAP_W-1:0] map_out_q;
    logic [PTR_W-1:0] row_ptr;
    logic [LC_W-1:0]  cnt;
    logic [LC_W-1:0]  lines_q;
    logic             busy_q;
    logic             done_q;
    logic             we_q;
    logic             row_full;
    logic             load;
    logic             dec_ptr;
    logic             do_shift;
    logic             commit;
    logic             finish;

    row_full_detect u_detect (
        .map      (work),
        .row_ptr  (row_ptr),
        .row_full (row_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec_ptr    = 1'b0;
        do_shift   = 1'b0;
        commit     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_next = SHIFT;
                end else if (row_ptr == '0) begin
                    state_next = COMMIT;
                end else begin
                    dec_ptr = 1'b1;
                end
            end
            SHIFT: begin
                do_shift   = 1'b1;
                state_next = SCAN;
            end
            COMMIT: begin
                // Nothing changed means nothing to write back, so skip the vblank wait
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (bus.vblank) begin
                    finish     = 1'b1;
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Rows at or above row_ptr drop by one; gutters and spare bits ride along untouched
    always_comb begin
        shifted = work;
        shifted[idx(0, 0) +: COLS] = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (r <= int'(row_ptr)) begin
                shifted[idx(r, 0) +: COLS] = work[idx(r - 1, 0) +: COLS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            row_ptr   <= '0;
            cnt       <= '0;
            lines_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            map_out_q <= '0;
        end else begin
            done_q <= finish;
            we_q   <= commit;
            if (load) begin
                work    <= bus.fixed_square_map;
                row_ptr <= PTR_W'(ROWS - 1);
                cnt     <= '0;
                busy_q  <= 1'b1;
            end
            if (dec_ptr) begin
                row_ptr <= row_ptr - 1'b1;
            end
            if (do_shift) begin
                work <= shifted;
                cnt  <= cnt + 1'b1;
            end
            if (commit) begin
                map_out_q <= work;
            end
            if (finish) begin
                busy_q  <= 1'b0;
                lines_q <= (cnt > LC_W'(ROWS)) ? LC_W'(ROWS) : cnt;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.map_we        = we_q;
    assign bus.map_out       = map_out_q;
    assign bus.lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_ctrl_module.sv
// Randomised bench for the line-clear sequencer, checked against a
// row-compaction model of the playfield.
module tb_line_clear_ctrl_module;
    import tetris_map_pkg::*;

    localparam int TB_ROWS   = 14;
    localparam int TB_OFS    = 5;
    localparam int TB_STRIDE = 20;
    localparam logic [9:0] FULL_ROW = 10'h3FF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_clear_ctrl_module_if bus();

    line_clear_ctrl_module dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int assert_count = 0;
    int fail_count   = 0;

    int               obs_done_cycle;
    int               obs_done_count;
    int               obs_we_count;
    int               obs_we_no_vblank;
    int               obs_busy_low;
    int               obs_relapse;
    logic [MAP_W-1:0] obs_map;
    logic [3:0]       obs_lc;

    function automatic logic [9:0] get_row(input logic [MAP_W-1:0] m, input int r);
        return 10'(m >> (TB_OFS + TB_STRIDE * r));
    endfunction

    function automatic logic [MAP_W-1:0] set_row(input logic [MAP_W-1:0] m, input int r,
                                                 input logic [9:0] v);
        logic [MAP_W-1:0] mask;
        mask = MAP_W'(FULL_ROW) << (TB_OFS + TB_STRIDE * r);
        return (m & ~mask) | (MAP_W'(v) << (TB_OFS + TB_STRIDE * r));
    endfunction

    function automatic logic [MAP_W-1:0] playfield_mask();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int r = 0; r < TB_ROWS; r++) m = set_row(m, r, FULL_ROW);
        return m;
    endfunction

    function automatic logic [MAP_W-1:0] rand_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int i = 0; i < 12; i++) m = {m[MAP_W-33:0], 32'($urandom)};
        return m;
    endfunction

    // Full rows vanish, survivors settle to the bottom in order, zeros fill the top
    function automatic logic [MAP_W-1:0] model_clear(input logic [MAP_W-1:0] m, output int k);
        logic [MAP_W-1:0] res;
        logic [9:0]       kept[$];
        res = m & ~playfield_mask();
        k   = 0;
        for (int r = TB_ROWS - 1; r >= 0; r--) begin
            if (get_row(m, r) == FULL_ROW) k++;
            else kept.push_back(get_row(m, r));
        end
        for (int i = 0; i < kept.size(); i++) res = set_row(res, TB_ROWS - 1 - i, kept[i]);
        return res;
    endfunction

    function automatic int model_done(input int k, input int vb_delay);
        int base;
        base = 15 + 2 * k;
        if (k == 0) return 15;
        return (vb_delay > base) ? vb_delay : base;
    endfunction

    // vblank is high at every edge numbered >= vb_delay (edge 0 samples start)
    task automatic applyStimulus(input logic [MAP_W-1:0] m, input int vb_delay,
                                 input int repulse, input int scramble);
        obs_done_cycle   = -1;
        obs_done_count   = 0;
        obs_we_count     = 0;
        obs_we_no_vblank = 0;
        obs_busy_low     = -1;
        obs_relapse      = 0;
        obs_map          = '0;
        obs_lc           = 4'hF;
        bus.fixed_square_map = m;
        bus.vblank = (vb_delay <= 0);
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.done) begin
                obs_done_count++;
                if (obs_done_cycle < 0) begin
                    obs_done_cycle = n;
                    obs_lc = bus.lines_cleared;
                end
            end
            if (bus.map_we) begin
                obs_we_count++;
                obs_map = bus.map_out;
                if (n < vb_delay) obs_we_no_vblank++;
            end
            if (obs_busy_low >= 0 && bus.busy) obs_relapse++;
            if (!bus.busy && obs_busy_low < 0) obs_busy_low = n;
            bus.vblank = (n + 1 >= vb_delay);
            bus.start  = (n == repulse);
            if (n == scramble) bus.fixed_square_map = rand_map();
            if (obs_done_cycle >= 0 && n >= obs_done_cycle + 5) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.vblank = 1'b0;
        bus.fixed_square_map = '0;
        repeat (2) @(negedge clk);
        assert_count++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.map_we !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_ctrl: busy/done/we=%b%b%b expected 000",
                     bus.busy, bus.done, bus.map_we);
        end
        assert_count++;
        if (bus.lines_cleared !== 4'd0 || bus.map_out !== '0) begin
            fail_count++;
            $display("[TB] FAIL reset_data: lines_cleared=%0d map_out=%h expected zero",
                     bus.lines_cleared, bus.map_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        assert_count++;
        if (bus.busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL idle_after_reset: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_empty();
        applyStimulus('0, 0, -1, -1);
        assert_count++;
        if (obs_done_cycle !== 15) begin
            fail_count++;
            $display("[TB] FAIL empty_done_cycle: got %0d expected 15", obs_done_cycle);
        end
        assert_count++;
        if (obs_we_count !== 0) begin
            fail_count++;
            $display("[TB] FAIL empty_no_we: got %0d strobes expected 0", obs_we_count);
        end
        assert_count++;
        if (obs_lc !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL empty_lines: got %0d expected 0", obs_lc);
        end
        assert_count++;
        if (obs_busy_low !== 15) begin
            fail_count++;
            $display("[TB] FAIL empty_busy_window: busy first low at %0d expected 15", obs_busy_low);
        end
    endtask

    task automatic test_single_row();
        logic [MAP_W-1:0] m, exp;
        int k;
        m = rand_map() & ~playfield_mask();
        m = set_row(m, 13, FULL_ROW);
        m = set_row(m, 12, 10'h155);
        exp = model_clear(m, k);
        applyStimulus(m, 0, -1, -1);
        assert_count++;
        if (obs_done_cycle !== 17) begin
            fail_count++;
            $display("[TB] FAIL single_done_cycle: got %0d expected 17", obs_done_cycle);
        end
        assert_count++;
        if (get_row(obs_map, 13) !== 10'h155 || get_row(obs_map, 0) !== 10'h000) begin
            fail_count++;
            $display("[TB] FAIL single_rows: row13=%h row0=%h expected 155 000",
                     get_row(obs_map, 13), get_row(obs_map, 0));
        end
        assert_count++;
        if (obs_map !== exp || obs_we_count !== 1) begin
            fail_count++;
            $display("[TB] FAIL single_map: we=%0d got %h expected %h", obs_we_count, obs_map, exp);
        end
        assert_count++;
        if (obs_lc !== 4'd1) begin
            fail_count++;
            $display("[TB] FAIL single_lines: got %0d expected 1", obs_lc);
        end
    endtask

    task automatic test_vblank_wait();
        logic [MAP_W-1:0] m, exp;
        int k;
        m = rand_map();
        for (int r = 0; r < 10; r++)
            if (get_row(m, r) == FULL_ROW) m = set_row(m, r, 10'h3FE);
        for (int r = 10; r < 14; r++) m = set_row(m, r, FULL_ROW);
        exp = model_clear(m, k);
        applyStimulus(m, 50, -1, -1);
        assert_count++;
        if (obs_done_cycle !== 50 || obs_we_no_vblank !== 0) begin
            fail_count++;
            $display("[TB] FAIL vblank_wait: done at %0d early_we=%0d expected 50 and 0",
                     obs_done_cycle, obs_we_no_vblank);
        end
        assert_count++;
        if (obs_lc !== 4'd4) begin
            fail_count++;
            $display("[TB] FAIL vblank_lines: got %0d expected 4", obs_lc);
        end
        assert_count++;
        if ((obs_map & ~playfield_mask()) !== (m & ~playfield_mask())) begin
            fail_count++;
            $display("[TB] FAIL vblank_gutters: got %h expected %h",
                     obs_map & ~playfield_mask(), m & ~playfield_mask());
        end
        assert_count++;
        if (obs_map !== exp || obs_we_count !== 1) begin
            fail_count++;
            $display("[TB] FAIL vblank_map: we=%0d got %h expected %h", obs_we_count, obs_map, exp);
        end
    endtask

    task automatic test_split_rows();
        logic [MAP_W-1:0] m, exp;
        int k;
        m = '0;
        m = set_row(m, 13, FULL_ROW);
        m = set_row(m, 12, 10'h0F0);
        m = set_row(m, 11, FULL_ROW);
        exp = model_clear(m, k);
        applyStimulus(m, 0, -1, -1);
        assert_count++;
        if (obs_done_cycle !== 19) begin
            fail_count++;
            $display("[TB] FAIL split_done_cycle: got %0d expected 19", obs_done_cycle);
        end
        assert_count++;
        if (get_row(obs_map, 13) !== 10'h0F0 || obs_map !== exp) begin
            fail_count++;
            $display("[TB] FAIL split_map: row13=%h map=%h expected %h", get_row(obs_map, 13), obs_map, exp);
        end
        assert_count++;
        if (obs_lc !== 4'd2) begin
            fail_count++;
            $display("[TB] FAIL split_lines: got %0d expected 2", obs_lc);
        end
    endtask

    task automatic test_restart_and_reset();
        logic [MAP_W-1:0] m;
        int seen;
        m = '0;
        m = set_row(m, 13, FULL_ROW);
        m = set_row(m, 12, 10'h00F);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(m, 0, (i == 0) ? 3 : 16, -1);
            assert_count++;
            if (obs_done_cycle !== 17 || obs_done_count !== 1 || obs_relapse !== 0) begin
                fail_count++;
                $display("[TB] FAIL restart_ignored[%0d]: done_at=%0d dones=%0d relapse=%0d expected 17 1 0",
                         i, obs_done_cycle, obs_done_count, obs_relapse);
            end
        end
        bus.fixed_square_map = m;
        bus.vblank = 1'b1;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        assert_count++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.map_we !== 1'b0 ||
            bus.lines_cleared !== 4'd0 || bus.map_out !== '0) begin
            fail_count++;
            $display("[TB] FAIL reset_mid_shift: busy=%b done=%b we=%b lines=%0d expected all zero",
                     bus.busy, bus.done, bus.map_we, bus.lines_cleared);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.map_we || bus.done) seen++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.map_we || bus.done || bus.busy) seen++;
        end
        assert_count++;
        if (seen !== 0) begin
            fail_count++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_snapshot();
        logic [MAP_W-1:0] m, exp;
        int k;
        m = rand_map();
        for (int r = 0; r < TB_ROWS; r++)
            if (get_row(m, r) == FULL_ROW) m = set_row(m, r, 10'h1FF);
        m = set_row(m, 13, FULL_ROW);
        m = set_row(m, 9, FULL_ROW);
        exp = model_clear(m, k);
        applyStimulus(m, 0, -1, 4);
        assert_count++;
        if (obs_map !== exp || obs_we_count !== 1) begin
            fail_count++;
            $display("[TB] FAIL snapshot_map: we=%0d got %h expected %h", obs_we_count, obs_map, exp);
        end
        assert_count++;
        if (obs_lc !== 4'(k) || obs_done_cycle !== model_done(k, 0)) begin
            fail_count++;
            $display("[TB] FAIL snapshot_timing: lines=%0d done_at=%0d expected %0d %0d",
                     obs_lc, obs_done_cycle, k, model_done(k, 0));
        end
    endtask

    task automatic checkOutput(input int iter, input logic [MAP_W-1:0] exp, input int k, input int vb);
        assert_count++;
        if (obs_done_cycle !== model_done(k, vb)) begin
            fail_count++;
            $display("[TB] FAIL random_done[%0d]: got %0d expected %0d", iter, obs_done_cycle, model_done(k, vb));
        end
        assert_count++;
        if (obs_lc !== 4'(k) || obs_we_count !== ((k > 0) ? 1 : 0)) begin
            fail_count++;
            $display("[TB] FAIL random_lines[%0d]: lines=%0d we=%0d expected %0d %0d",
                     iter, obs_lc, obs_we_count, k, (k > 0) ? 1 : 0);
        end
        if (k > 0) begin
            assert_count++;
            if (obs_map !== exp) begin
                fail_count++;
                $display("[TB] FAIL random_map[%0d]: got %h expected %h", iter, obs_map, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [MAP_W-1:0] m, exp;
        int k, vb;
        for (int i = 0; i < 20; i++) begin
            m = rand_map();
            for (int r = 0; r < TB_ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) m = set_row(m, r, FULL_ROW);
                else if (get_row(m, r) == FULL_ROW) m = set_row(m, r, 10'h2FF);
            end
            vb  = $urandom_range(0, 40);
            exp = model_clear(m, k);
            applyStimulus(m, vb, -1, -1);
            checkOutput(i, exp, k, vb);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_row();
        test_vblank_wait();
        test_split_rows();
        test_restart_and_reset();
        test_snapshot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
